// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and default constants for the Gigatron clock/reset start-up logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gigatron_clk_pkg;

  // Lock sequencer states, in start-up order.
  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    STABILIZE  = 2'd1,
    HOLD_RESET = 2'd2,
    RUN        = 2'd3
  } lockseq_state_t;

  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_RESET_HOLD_CYCLES  = 16;
  localparam int DEF_CE_FAST_DIV        = 2;
  localparam int DEF_CE_SLOW_DIV        = 8;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs (PLL lock, buttons, PS/2).
// Latency: 2 clk edges from input to q. Backpressure: none.
// Ports: clk, rst (sync active-high, clears both flops), d (async input), q (synchronised output).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Turns the PLL lock signal into an ordered core start-up plus phase-aligned clock enables.
// Latency: sys_reset falls 3+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES edges after lock is first sampled.
// Backpressure: none; any drop of the synchronised lock restarts the full sequence.
// Ports: clk, rst (sync active-high), locked (async PLL lock) -> sys_reset, ready,
//        ce_fast, ce_slow (one-cycle strobes in RUN), lock_lost (sticky), loss_count (saturating).
module pll_lock_sequencer
  import gigatron_clk_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int CE_FAST_DIV        = DEF_CE_FAST_DIV,
  parameter int CE_SLOW_DIV        = DEF_CE_SLOW_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce_fast,
  output logic       ce_slow,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  if (LOCK_STABLE_CYCLES < 1 || RESET_HOLD_CYCLES < 1) begin : g_bad_cycles
    $error("pll_lock_sequencer: stable window and reset hold must each be at least 1 cycle");
  end
  if (CE_FAST_DIV < 1 || (CE_SLOW_DIV % CE_FAST_DIV) != 0) begin : g_bad_div
    $error("pll_lock_sequencer: CE_SLOW_DIV must be a multiple of CE_FAST_DIV");
  end

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                           LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int DIV_W   = cnt_width(CE_SLOW_DIV);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_SLOW_DIV - 1);

  logic locked_s;

  lockseq_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       loss_count_q, loss_count_d;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // State register (with the counters and loss tracking that move with it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      div_q        <= '0;
      lock_lost_q  <= 1'b0;
      loss_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STAB_LAST) begin
          state_d = HOLD_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD_RESET: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d     = WAIT_LOCK;
          lock_lost_d = 1'b1;
          if (loss_count_q != 8'hFF) begin
            loss_count_d = loss_count_q + 8'd1;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    // The divider only advances while staying in RUN, so it is zero on RUN
    // entry and the first RUN cycle carries both strobes.
    div_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Output decode, straight from the registers.
  always_comb begin
    sys_reset  = 1'b1;
    ready      = 1'b0;
    ce_fast    = 1'b0;
    ce_slow    = 1'b0;
    if (state_q == RUN) begin
      sys_reset = 1'b0;
      ready     = 1'b1;
      ce_slow   = (div_q == '0);
      ce_fast   = ((int'(div_q) % CE_FAST_DIV) == 0);
    end
    lock_lost  = lock_lost_q;
    loss_count = loss_count_q;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with a lock-streak reference model.
// Latency: n/a. Backpressure: n/a.
// Ports: none (top-level bench).
module tb_pll_lock_sequencer;

  localparam int L    = 8;
  localparam int H    = 4;
  localparam int FDIV = 2;
  localparam int SDIV = 8;
  // Consecutive edges with lock seen high needed before RUN is reached.
  localparam int RUN_STREAK = L + H + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       sys_reset, ready, ce_fast, ce_slow, lock_lost;
  logic [7:0] loss_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: lock history pipeline, length of the unbroken
  // high-lock streak seen by the sequencer, and loss bookkeeping.
  bit m_p1 = 1'b0;
  bit m_p2 = 1'b0;
  int m_streak = 0;
  bit m_lost = 1'b0;
  int m_loss = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .RESET_HOLD_CYCLES  (H),
    .CE_FAST_DIV        (FDIV),
    .CE_SLOW_DIV        (SDIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .locked     (locked),
    .sys_reset  (sys_reset),
    .ready      (ready),
    .ce_fast    (ce_fast),
    .ce_slow    (ce_slow),
    .lock_lost  (lock_lost),
    .loss_count (loss_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit l);
    bit seen;
    if (r) begin
      m_p1 = 1'b0; m_p2 = 1'b0; m_streak = 0; m_lost = 1'b0; m_loss = 0;
    end else begin
      seen = m_p2;
      m_p2 = m_p1;
      m_p1 = l;
      if (seen) begin
        m_streak++;
      end else begin
        if (m_streak >= RUN_STREAK) begin
          m_lost = 1'b1;
          if (m_loss < 255) m_loss++;
        end
        m_streak = 0;
      end
    end
  endtask

  // Apply inputs for one edge, advance the model, then compare just after the edge.
  task automatic step(input bit r, input bit l);
    bit run;
    int age;
    rst    = r;
    locked = l;
    @(posedge clk);
    model_edge(r, l);
    #1;
    run = (m_streak >= RUN_STREAK);
    age = m_streak - RUN_STREAK;
    check("sys_reset",  int'(sys_reset),  int'(!run));
    check("ready",      int'(ready),      int'(run));
    check("ce_fast",    int'(ce_fast),    int'(run && (age % FDIV) == 0));
    check("ce_slow",    int'(ce_slow),    int'(run && (age % SDIV) == 0));
    check("lock_lost",  int'(lock_lost),  int'(m_lost));
    check("loss_count", int'(loss_count), m_loss);
  endtask

  // Hold lock high and report the edge (1-based) at which sys_reset first falls.
  task automatic measure_rise(output int fall_edge);
    fall_edge = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1);
      if (fall_edge < 0 && !sys_reset) fall_edge = k;
    end
  endtask

  initial begin
    int edge_n;
    int total;
    bit lv;
    int len;

    // Reset, then long idle with no lock.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0);

    // Clean rise.
    measure_rise(edge_n);
    check("rise_latency", edge_n, 15);

    // Drop while running, then re-lock.
    edge_n = -1;
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b0);
      if (edge_n < 0 && sys_reset) edge_n = k;
    end
    check("drop_latency", edge_n, 3);
    check("lost_after_drop", int'(lock_lost), 1);
    check("count_after_drop", int'(loss_count), 1);
    measure_rise(edge_n);
    check("relock_latency", edge_n, 15);
    check("lost_sticky", int'(lock_lost), 1);

    // Glitch during the stable window restarts the sequence.
    step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    measure_rise(edge_n);
    check("glitch_latency", edge_n, 15);
    check("glitch_no_loss", int'(lock_lost), 0);

    // Reset during HOLD_RESET: lock entered STABILIZE at edge 3, HOLD at edge 11.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    check("rst_hold_sysrst", int'(sys_reset), 1);

    // Random lock/unlock runs with occasional resets.
    total = 0;
    while (total < 4000) begin
      lv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 299) == 0), lv);
        total++;
      end
    end

    // Saturate the loss counter.
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    end
    check("loss_saturated", int'(loss_count), 255);

    // Reset from RUN with a saturated counter.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check("in_run_before_rst", int'(ready), 1);
    step(1'b1, 1'b1);
    check("rst_run_sysrst", int'(sys_reset), 1);
    check("rst_run_lost", int'(lock_lost), 0);
    check("rst_run_count", int'(loss_count), 0);
    check("rst_run_ce", int'(ce_fast | ce_slow), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Consumes the PLL's `locked` output on the 50 MHz system clock and turns it into a clean, ordered start-up for the Gigatron core. It synchronises `locked`, requires it to stay high for a programmable stable window, then holds core reset for a fixed number of cycles before release. After release it generates phase-aligned 25 MHz and 6.25 MHz clock-enable strobes, which replace extra PLL outputs for the video and CPU domains. It sits between the PLL wrapper and the core top level. Loss of lock is tracked in a sticky flag and a saturating counter.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: cycles the synchronised lock must stay high before reset hold begins; must be ≥ 1.
- `RESET_HOLD_CYCLES`, default 16: cycles `sys_reset` stays asserted after the stable window; must be ≥ 1.
- `CE_FAST_DIV`, default 2: period of `ce_fast` in clocks (25 MHz from 50 MHz).
- `CE_SLOW_DIV`, default 8: period of `ce_slow` in clocks (6.25 MHz); must be a multiple of `CE_FAST_DIV`. Violation is an elaboration error.

Ports:
- `clk`  in  1  50 MHz system clock, which is PLL output 0.
- `rst`  in  1  synchronous, active-high reset. This is decided: one clock, synchronous active-high reset.
- `locked`  in  1  PLL lock, asynchronous to `clk`.
- `sys_reset`  out  1  core reset, active-high.
- `ready`  out  1  high in RUN; equals `~sys_reset`.
- `ce_fast`  out  1  one-cycle strobe every `CE_FAST_DIV` clocks in RUN.
- `ce_slow`  out  1  one-cycle strobe every `CE_SLOW_DIV` clocks in RUN.
- `lock_lost`  out  1  sticky flag: lock dropped while in RUN.
- `loss_count`  out  8  number of RUN→WAIT_LOCK transitions; saturates at 255.

## Operation
- `locked` passes through a two-flop synchroniser to produce `locked_s`.
- States:
  - WAIT_LOCK: if `locked_s`=1, go to STABILIZE and clear `cnt`.
  - STABILIZE: if `locked_s`=0, go to WAIT_LOCK. Otherwise increment `cnt`; at `cnt`=`LOCK_STABLE_CYCLES`−1, go to HOLD_RESET and clear `cnt`.
  - HOLD_RESET: if `locked_s`=0, go to WAIT_LOCK. Otherwise increment `cnt`; at `cnt`=`RESET_HOLD_CYCLES`−1, go to RUN.
  - RUN: if `locked_s`=0, go to WAIT_LOCK, set `lock_lost`, and increment `loss_count` unless it is 255.
- `sys_reset` = (state ≠ RUN), decoded directly from the state register with no extra flop.
- Divider counter `div` has width ceil(log2(`CE_SLOW_DIV`)).
  - Forced to 0 in every state except RUN.
  - In RUN it counts modulo `CE_SLOW_DIV`.
  - `ce_slow` = RUN && `div`==0.
  - `ce_fast` = RUN && (`div` mod `CE_FAST_DIV`)==0.
  - Every `ce_slow` pulse therefore coincides with a `ce_fast` pulse.
- `cnt` is sized for max(`LOCK_STABLE_CYCLES`, `RESET_HOLD_CYCLES`) and never wraps.

## Timing
- Reset state (`rst`=1 at an edge): WAIT_LOCK, synchroniser flops 0, `cnt`=0, `div`=0. Outputs are `sys_reset`=1, `ready`=0, `ce_fast`=0, `ce_slow`=0, `lock_lost`=0, `loss_count`=0.
- `rst` overrides everything in any state, including mid-STABILIZE and RUN.
- Rise path: let edge 1 be the first edge that samples `locked`=1.
  - STABILIZE is entered at edge 3.
  - HOLD_RESET is entered at edge 3+`LOCK_STABLE_CYCLES`.
  - RUN is entered and `sys_reset` falls at edge 3+`LOCK_STABLE_CYCLES`+`RESET_HOLD_CYCLES`. With defaults this is edge 1043.
- First RUN cycle: `ce_fast`=1 and `ce_slow`=1. After that, `ce_fast` repeats every 2 cycles and `ce_slow` every 8.
- Drop path: let edge 1 be the first edge that samples `locked`=0. WAIT_LOCK is entered at edge 3. If the drop came from RUN, then at that same edge `sys_reset`=1, both CEs are 0, and `lock_lost`/`loss_count` update.
- A glitch shorter than one clock may be missed. Any drop seen on `locked_s` during STABILIZE or HOLD_RESET restarts the full sequence.
- A re-lock after a loss repeats the full stable window and reset hold.

## Structure
- Shared package `gigatron_clk_pkg` holds:
  - the state enum `lockseq_state_t` {WAIT_LOCK, STABILIZE, HOLD_RESET, RUN};
  - default constants for the four parameters.
- Sub-module `sync_2ff` is the single-bit two-flop synchroniser. It is reusable for other asynchronous inputs such as button and PS/2 lines.

## Test plan
Use `LOCK_STABLE_CYCLES`=8 and `RESET_HOLD_CYCLES`=4 unless a test states otherwise.
- Reset with `locked`=0 held for 50 cycles: `sys_reset`=1, `ready`=0, both CEs 0, `lock_lost`=0, and `loss_count`=0 throughout.
- `locked` rises at edge 1 and stays high: `sys_reset` falls at edge 15. From edge 15 on, `ce_fast` pulses at edges 15, 17, 19, … and `ce_slow` at edges 15, 23, 31, ….
- `locked` drops for 3 cycles at the 5th STABILIZE cycle, then returns: the sequence restarts, `sys_reset` falls 15 edges after the re-rise, and `lock_lost` stays 0.
- `locked` drops in RUN: `sys_reset` rises and the CEs stop 3 edges after the drop, `lock_lost`=1, and `loss_count`=1. On re-lock, RUN resumes after another 15 edges with `lock_lost` still 1.
- Force 256 RUN→WAIT_LOCK cycles: `loss_count` saturates at 255. Then assert `rst`: all outputs return to their reset values at the next edge.
- Assert `rst` during HOLD_RESET and during RUN: WAIT_LOCK is entered at the next edge, `sys_reset`=1, and `lock_lost` is cleared.
